// File: rtl/adc5g_gray_decode_pipe.sv
// Pipelined Gray-to-binary decoder for the ADC5G demux path: NUM_CH samples per beat,
// offset-binary / two's-complement / bypass output, sticky over-range flags and beat counter.
module adc5g_gray_decode_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CH      = 4,
   parameter int PIPE_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [1:0]                   mode,
   input  logic                         ovr_clr,
   output logic                         out_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            ovr_flag,
   output logic [15:0]                  ovr_count
);

   localparam int BUS_W = NUM_CH * DATA_WIDTH;
   localparam int GRP_W = (DATA_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;
   localparam int LAST  = PIPE_STAGES - 1;

   localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
   localparam logic [15:0]           CNT_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      MODE_OFFSET = 2'b00,
      MODE_BYPASS = 2'b01,
      MODE_TWOS   = 2'b10
   } mode_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] word;
      logic                  par;
   } res_t;

   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_BYPASS;
         2'b10:   return MODE_TWOS;
         default: return MODE_OFFSET;
      endcase
   endfunction

   // Resolves the MSB-first bit group owned by 'stage'. Bits above the group are already
   // binary, bits below stay Gray; par carries the binary value of the lowest resolved bit.
   function automatic res_t resolve_group(input logic [DATA_WIDTH-1:0] gc,
                                          input logic                  par_in,
                                          input int                    stage);
      res_t r;
      int   hi;
      int   lo;
      hi     = DATA_WIDTH - 1 - stage * GRP_W;
      lo     = DATA_WIDTH - (stage + 1) * GRP_W;
      if (lo < 0) lo = 0;
      r.word = gc;
      r.par  = par_in;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (i <= hi && i >= lo) begin
            r.par     = r.par ^ gc[i];
            r.word[i] = r.par;
         end
      end
      return r;
   endfunction

   logic [PIPE_STAGES-1:0] src_vld;
   logic [BUS_W-1:0]       src_dat  [PIPE_STAGES];
   logic [NUM_CH-1:0]      src_par  [PIPE_STAGES];
   mode_e                  src_mode [PIPE_STAGES];

   logic [PIPE_STAGES-1:0] vld_d,  vld_q;
   logic [BUS_W-1:0]       dat_d  [PIPE_STAGES];
   logic [BUS_W-1:0]       dat_q  [PIPE_STAGES];
   logic [NUM_CH-1:0]      par_d  [PIPE_STAGES];
   logic [NUM_CH-1:0]      par_q  [PIPE_STAGES];
   mode_e                  mode_d [PIPE_STAGES];
   mode_e                  mode_q [PIPE_STAGES];

   logic [NUM_CH-1:0]      ovr_vec;
   logic [NUM_CH-1:0]      ovr_flag_d,  ovr_flag_q;
   logic [15:0]            ovr_count_d, ovr_count_q;

   always_comb begin : p_src
      src_vld[0]  = in_valid;
      src_dat[0]  = in_data;
      src_par[0]  = '0;
      src_mode[0] = decode_mode(mode);
      for (int k = 1; k < PIPE_STAGES; k++) begin
         src_vld[k]  = vld_q[k-1];
         src_dat[k]  = dat_q[k-1];
         src_par[k]  = par_q[k-1];
         src_mode[k] = mode_q[k-1];
      end
   end

   always_comb begin : p_stage
      res_t                  r;
      logic [DATA_WIDTH-1:0] fin;
      // NOTE: every output gets a default before any branch, so no latches are inferred.
      r       = '0;
      fin     = '0;
      ovr_vec = '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
         vld_d[k]  = src_vld[k];
         mode_d[k] = src_mode[k];
         dat_d[k]  = src_dat[k];
         par_d[k]  = src_par[k];
         if (src_mode[k] != MODE_BYPASS) begin
            for (int c = 0; c < NUM_CH; c++) begin
               r = resolve_group(src_dat[k][c*DATA_WIDTH +: DATA_WIDTH], src_par[k][c], k);
               dat_d[k][c*DATA_WIDTH +: DATA_WIDTH] = r.word;
               par_d[k][c]                          = r.par;
            end
         end
      end
      // Over-range looks at the offset-binary (or raw bypass) word before the MSB flip.
      for (int c = 0; c < NUM_CH; c++) begin
         fin        = dat_d[LAST][c*DATA_WIDTH +: DATA_WIDTH];
         ovr_vec[c] = (fin == '0) || (fin == ALL_ONES);
         if (src_mode[LAST] == MODE_TWOS) begin
            dat_d[LAST][c*DATA_WIDTH + DATA_WIDTH - 1] = ~fin[DATA_WIDTH-1];
         end
      end
   end

   always_comb begin : p_ovr
      ovr_flag_d  = ovr_flag_q;
      ovr_count_d = ovr_count_q;
      if (ovr_clr) begin
         ovr_flag_d  = '0;
         ovr_count_d = '0;
      end else if (vld_d[LAST]) begin
         ovr_flag_d = ovr_flag_q | ovr_vec;
         if ((|ovr_vec) && (ovr_count_q != CNT_MAX)) begin
            ovr_count_d = ovr_count_q + 16'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every stage samples
   // the previous stage's pre-edge value.
   always_ff @(posedge clk) begin : p_regs
      if (rst) begin
         vld_q       <= '0;
         ovr_flag_q  <= '0;
         ovr_count_q <= '0;
         // NOTE: stage data is reset as well; the last stage is out_data, which must read 0.
         for (int k = 0; k < PIPE_STAGES; k++) begin
            dat_q[k]  <= '0;
            par_q[k]  <= '0;
            mode_q[k] <= MODE_OFFSET;
         end
      end else begin
         vld_q       <= vld_d;
         ovr_flag_q  <= ovr_flag_d;
         ovr_count_q <= ovr_count_d;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            if (vld_d[k]) begin
               dat_q[k]  <= dat_d[k];
               par_q[k]  <= par_d[k];
               mode_q[k] <= mode_d[k];
            end
         end
      end
   end

   assign out_valid = vld_q[LAST];
   assign out_data  = dat_q[LAST];
   assign ovr_flag  = ovr_flag_q;
   assign ovr_count = ovr_count_q;

endmodule

// File: tb/tb_adc5g_gray_decode_pipe.sv
// Self-checking bench for adc5g_gray_decode_pipe: three configurations share one clock,
// each with a queue-based scoreboard of expected output beats and their due cycles.
module tb_adc5g_gray_decode_pipe;

   localparam int AW = 4, AN = 2, AP = 2;
   localparam int BW = 8, BN = 4, BP = 2;
   localparam int CW = 8, CN = 4, CP = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t exp_c[$];

   logic             rst_a, in_valid_a, ovr_clr_a, out_valid_a;
   logic [AN*AW-1:0] in_data_a, out_data_a;
   logic [1:0]       mode_a;
   logic [AN-1:0]    ovr_flag_a;
   logic [15:0]      ovr_count_a;

   logic             rst_b, in_valid_b, ovr_clr_b, out_valid_b;
   logic [BN*BW-1:0] in_data_b, out_data_b;
   logic [1:0]       mode_b;
   logic [BN-1:0]    ovr_flag_b;
   logic [15:0]      ovr_count_b;

   logic             rst_c, in_valid_c, ovr_clr_c, out_valid_c;
   logic [CN*CW-1:0] in_data_c, out_data_c;
   logic [1:0]       mode_c;
   logic [CN-1:0]    ovr_flag_c;
   logic [15:0]      ovr_count_c;

   adc5g_gray_decode_pipe #(.DATA_WIDTH(AW), .NUM_CH(AN), .PIPE_STAGES(AP)) dut_a (
      .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_data(in_data_a), .mode(mode_a),
      .ovr_clr(ovr_clr_a), .out_valid(out_valid_a), .out_data(out_data_a),
      .ovr_flag(ovr_flag_a), .ovr_count(ovr_count_a));

   adc5g_gray_decode_pipe #(.DATA_WIDTH(BW), .NUM_CH(BN), .PIPE_STAGES(BP)) dut_b (
      .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_data(in_data_b), .mode(mode_b),
      .ovr_clr(ovr_clr_b), .out_valid(out_valid_b), .out_data(out_data_b),
      .ovr_flag(ovr_flag_b), .ovr_count(ovr_count_b));

   adc5g_gray_decode_pipe #(.DATA_WIDTH(CW), .NUM_CH(CN), .PIPE_STAGES(CP)) dut_c (
      .clk(clk), .rst(rst_c), .in_valid(in_valid_c), .in_data(in_data_c), .mode(mode_c),
      .ovr_clr(ovr_clr_c), .out_valid(out_valid_c), .out_data(out_data_c),
      .ovr_flag(ovr_flag_c), .ovr_count(ovr_count_c));

   // Reference: bin = g ^ g>>1 ^ g>>2 ^ ...
   function automatic logic [15:0] g2b(input logic [15:0] g, input int w);
      logic [15:0] b;
      b = '0;
      for (int s = 0; s < w; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic logic [15:0] b2g(input int n);
      return 16'(n ^ (n >> 1));
   endfunction

   function automatic logic [31:0] model_data(input logic [31:0] din, input logic [1:0] m,
                                              input int w, input int n);
      logic [31:0] res;
      logic [15:0] mask;
      logic [15:0] raw;
      logic [15:0] val;
      res  = '0;
      mask = 16'((32'd1 << w) - 32'd1);
      for (int c = 0; c < n; c++) begin
         raw = 16'(din >> (c * w)) & mask;
         val = (m == 2'b01) ? raw : g2b(raw, w);
         if (m == 2'b10) val = val ^ 16'(32'd1 << (w - 1));
         res = res | (32'(val) << (c * w));
      end
      return res;
   endfunction

   task automatic test_reset();
      n_assert++;
      if (out_valid_a !== 1'b0 || out_data_a !== '0 || ovr_flag_a !== '0 || ovr_count_a !== '0) begin
         n_fail++;
         $display("FAIL reset_a: got valid=%b data=%h flag=%b count=%h, want 0/0/0/0",
                  out_valid_a, out_data_a, ovr_flag_a, ovr_count_a);
      end
      n_assert++;
      if (out_valid_b !== 1'b0 || out_data_b !== '0 || ovr_flag_b !== '0 || ovr_count_b !== '0) begin
         n_fail++;
         $display("FAIL reset_b: got valid=%b data=%h flag=%b count=%h, want 0/0/0/0",
                  out_valid_b, out_data_b, ovr_flag_b, ovr_count_b);
      end
      n_assert++;
      if (out_valid_c !== 1'b0 || out_data_c !== '0 || ovr_flag_c !== '0 || ovr_count_c !== '0) begin
         n_fail++;
         $display("FAIL reset_c: got valid=%b data=%h flag=%b count=%h, want 0/0/0/0",
                  out_valid_c, out_data_c, ovr_flag_c, ovr_count_c);
      end
   endtask

   task automatic test_exhaustive();
      logic [15:0] gl, gh;
      logic        exp_v;
      exp_t        e;
      int          dut_beats;
      dut_beats = 0;
      for (int i = 0; i < 16 + AP + 1; i++) begin
         if (i < 16) begin
            gl         = b2g(i);
            gh         = b2g(15 - i);
            in_valid_a = 1'b1;
            in_data_a  = {gh[3:0], gl[3:0]};
            mode_a     = 2'b00;
            exp_a.push_back('{data: {24'd0, 4'(15 - i), 4'(i)}, due: cyc + AP});
         end else begin
            in_valid_a = 1'b0;
         end
         @(posedge clk); #1;
         if (out_valid_a === 1'b1) dut_beats++;
         exp_v = (exp_a.size() > 0) && (exp_a[0].due == cyc);
         n_assert++;
         if (out_valid_a !== exp_v) begin
            n_fail++;
            $display("FAIL exh_valid cyc=%0d: got %b want %b", cyc, out_valid_a, exp_v);
         end
         if (exp_v) begin
            e = exp_a.pop_front();
            n_assert++;
            if (out_data_a !== e.data[7:0]) begin
               n_fail++;
               $display("FAIL exh_data cyc=%0d: got %h want %h", cyc, out_data_a, e.data[7:0]);
            end
         end
      end
      n_assert++;
      if (dut_beats != 16) begin
         n_fail++;
         $display("FAIL exh_beats: got %0d want 16", dut_beats);
      end
   endtask

   task automatic test_twos();
      logic [3:0] gc   [3] = '{4'b0110, 4'b1000, 4'b0000};
      logic [3:0] want [3] = '{4'b1100, 4'b0111, 4'b1000};
      logic       exp_v;
      exp_t       e;
      for (int i = 0; i < 3 + AP + 1; i++) begin
         if (i < 3) begin
            in_valid_a = 1'b1;
            in_data_a  = {gc[i], gc[i]};
            mode_a     = 2'b10;
            exp_a.push_back('{data: {24'd0, want[i], want[i]}, due: cyc + AP});
         end else begin
            in_valid_a = 1'b0;
            mode_a     = 2'b00;
         end
         @(posedge clk); #1;
         exp_v = (exp_a.size() > 0) && (exp_a[0].due == cyc);
         n_assert++;
         if (out_valid_a !== exp_v) begin
            n_fail++;
            $display("FAIL twos_valid cyc=%0d: got %b want %b", cyc, out_valid_a, exp_v);
         end
         if (exp_v) begin
            e = exp_a.pop_front();
            n_assert++;
            if (out_data_a !== e.data[7:0]) begin
               n_fail++;
               $display("FAIL twos_data cyc=%0d: got %h want %h", cyc, out_data_a, e.data[7:0]);
            end
         end
      end
   endtask

   task automatic test_over_range();
      logic        exp_v;
      exp_t        e;
      logic [15:0] exp_cnt;
      // Clear whatever earlier tests accumulated
      ovr_clr_a  = 1'b1;
      in_valid_a = 1'b0;
      @(posedge clk); #1;
      ovr_clr_a  = 1'b0;
      n_assert++;
      if (ovr_flag_a !== 2'b00 || ovr_count_a !== 16'd0) begin
         n_fail++;
         $display("FAIL ovr_clr_idle: got flag=%b count=%h want 00/0000", ovr_flag_a, ovr_count_a);
      end
      // One beat: ch0 Gray 1000 -> 1111 (over range), ch1 Gray 0110 -> 0100
      for (int i = 0; i < AP; i++) begin
         in_valid_a = (i == 0);
         in_data_a  = {4'b0110, 4'b1000};
         mode_a     = 2'b00;
         if (i == 0) exp_a.push_back('{data: {24'd0, 4'b0100, 4'b1111}, due: cyc + AP});
         @(posedge clk); #1;
         exp_v = (exp_a.size() > 0) && (exp_a[0].due == cyc);
         n_assert++;
         if (out_valid_a !== exp_v) begin
            n_fail++;
            $display("FAIL ovr_one_valid cyc=%0d: got %b want %b", cyc, out_valid_a, exp_v);
         end
         n_assert++;
         if (ovr_flag_a !== (exp_v ? 2'b01 : 2'b00) || ovr_count_a !== (exp_v ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL ovr_one_flags cyc=%0d: got flag=%b count=%h want %b/%h", cyc,
                     ovr_flag_a, ovr_count_a, exp_v ? 2'b01 : 2'b00, exp_v ? 16'd1 : 16'd0);
         end
         if (exp_v) begin
            e = exp_a.pop_front();
            n_assert++;
            if (out_data_a !== e.data[7:0]) begin
               n_fail++;
               $display("FAIL ovr_one_data: got %h want %h", out_data_a, e.data[7:0]);
            end
         end
      end
      // 0xFFFF more over-range beats: count must stick at 0xFFFF
      exp_cnt = 16'd1;
      for (int i = 0; i < 65535 + AP; i++) begin
         in_valid_a = (i < 65535);
         in_data_a  = {4'b0110, 4'b1000};
         if (i < 65535) exp_a.push_back('{data: {24'd0, 4'b0100, 4'b1111}, due: cyc + AP});
         @(posedge clk); #1;
         exp_v = (exp_a.size() > 0) && (exp_a[0].due == cyc);
         n_assert++;
         if (out_valid_a !== exp_v) begin
            n_fail++;
            $display("FAIL ovr_sat_valid cyc=%0d: got %b want %b", cyc, out_valid_a, exp_v);
         end
         if (exp_v) begin
            e       = exp_a.pop_front();
            exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
            n_assert++;
            if (ovr_count_a !== exp_cnt || ovr_flag_a !== 2'b01 || out_data_a !== e.data[7:0]) begin
               n_fail++;
               $display("FAIL ovr_sat cyc=%0d: got count=%h flag=%b data=%h want %h/01/%h", cyc,
                        ovr_count_a, ovr_flag_a, out_data_a, exp_cnt, e.data[7:0]);
            end
         end
      end
      n_assert++;
      if (ovr_count_a !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL ovr_sat_final: got %h want ffff", ovr_count_a);
      end
      // ovr_clr in the same cycle as an over-range output beat
      for (int i = 0; i < AP; i++) begin
         in_valid_a = (i == 0);
         ovr_clr_a  = (i == AP - 1);
         if (i == 0) exp_a.push_back('{data: {24'd0, 4'b0100, 4'b1111}, due: cyc + AP});
         @(posedge clk); #1;
         exp_v = (exp_a.size() > 0) && (exp_a[0].due == cyc);
         n_assert++;
         if (out_valid_a !== exp_v) begin
            n_fail++;
            $display("FAIL ovr_clr_valid cyc=%0d: got %b want %b", cyc, out_valid_a, exp_v);
         end
         if (exp_v) begin
            e = exp_a.pop_front();
            n_assert++;
            if (ovr_flag_a !== 2'b00 || ovr_count_a !== 16'd0) begin
               n_fail++;
               $display("FAIL ovr_clr_beat: got flag=%b count=%h want 00/0000", ovr_flag_a, ovr_count_a);
            end
         end
      end
      ovr_clr_a  = 1'b0;
      in_valid_a = 1'b0;
   endtask

   task automatic test_mode_switch();
      logic exp_v;
      exp_t e;
      for (int i = 0; i < 5 + BP + 1; i++) begin
         if (i < 5) begin
            in_valid_b = 1'b1;
            in_data_b  = 32'h80808080;
            mode_b     = (i < 3) ? 2'b00 : 2'b01;
            exp_b.push_back('{data: (i < 3) ? 32'hFFFFFFFF : 32'h80808080, due: cyc + BP});
         end else begin
            in_valid_b = 1'b0;
            mode_b     = 2'b10;
         end
         @(posedge clk); #1;
         exp_v = (exp_b.size() > 0) && (exp_b[0].due == cyc);
         n_assert++;
         if (out_valid_b !== exp_v) begin
            n_fail++;
            $display("FAIL mode_valid cyc=%0d: got %b want %b", cyc, out_valid_b, exp_v);
         end
         if (exp_v) begin
            e = exp_b.pop_front();
            n_assert++;
            if (out_data_b !== e.data) begin
               n_fail++;
               $display("FAIL mode_data cyc=%0d: got %h want %h", cyc, out_data_b, e.data);
            end
         end
      end
      mode_b = 2'b00;
   endtask

   task automatic test_gapped();
      logic        exp_v;
      exp_t        e;
      logic [31:0] d;
      logic [31:0] last_data;
      logic        have_last;
      have_last = 1'b0;
      last_data = '0;
      for (int i = 0; i < 6; i++) begin
         d          = $urandom;
         in_valid_b = (i == 0 || i == 2);
         in_data_b  = d;
         mode_b     = 2'b00;
         if (in_valid_b) exp_b.push_back('{data: model_data(d, 2'b00, BW, BN), due: cyc + BP});
         @(posedge clk); #1;
         exp_v = (exp_b.size() > 0) && (exp_b[0].due == cyc);
         n_assert++;
         if (out_valid_b !== exp_v) begin
            n_fail++;
            $display("FAIL gap_valid cyc=%0d: got %b want %b", cyc, out_valid_b, exp_v);
         end
         if (exp_v) begin
            e         = exp_b.pop_front();
            last_data = e.data;
            have_last = 1'b1;
            n_assert++;
            if (out_data_b !== e.data) begin
               n_fail++;
               $display("FAIL gap_data cyc=%0d: got %h want %h", cyc, out_data_b, e.data);
            end
         end else if (have_last) begin
            n_assert++;
            if (out_data_b !== last_data) begin
               n_fail++;
               $display("FAIL gap_hold cyc=%0d: got %h want %h", cyc, out_data_b, last_data);
            end
         end
      end
      in_valid_b = 1'b0;
   endtask

   task automatic test_reset_midstream();
      logic        exp_v;
      exp_t        e;
      logic [31:0] d;
      // Prime outputs and flags with a non-zero, over-range result
      for (int i = 0; i < CP; i++) begin
         in_valid_c = (i == 0);
         in_data_c  = 32'h80808080;
         mode_c     = 2'b00;
         if (i == 0) exp_c.push_back('{data: 32'hFFFFFFFF, due: cyc + CP});
         @(posedge clk); #1;
         exp_v = (exp_c.size() > 0) && (exp_c[0].due == cyc);
         n_assert++;
         if (out_valid_c !== exp_v) begin
            n_fail++;
            $display("FAIL rst_prime_valid cyc=%0d: got %b want %b", cyc, out_valid_c, exp_v);
         end
         if (exp_v) begin
            e = exp_c.pop_front();
            n_assert++;
            if (out_data_c !== e.data || ovr_flag_c !== 4'hF || ovr_count_c !== 16'd1) begin
               n_fail++;
               $display("FAIL rst_prime: got data=%h flag=%h count=%h want %h/f/0001",
                        out_data_c, ovr_flag_c, ovr_count_c, e.data);
            end
         end
      end
      // Three beats, reset with the third, fresh beat right after
      for (int i = 0; i < 7; i++) begin
         d          = $urandom;
         rst_c      = (i == 2);
         in_valid_c = (i <= 3);
         in_data_c  = d;
         if (in_valid_c) exp_c.push_back('{data: model_data(d, 2'b00, CW, CN), due: cyc + CP});
         if (rst_c) exp_c.delete();
         @(posedge clk); #1;
         exp_v = (exp_c.size() > 0) && (exp_c[0].due == cyc);
         n_assert++;
         if (out_valid_c !== exp_v) begin
            n_fail++;
            $display("FAIL rst_mid_valid cyc=%0d: got %b want %b", cyc, out_valid_c, exp_v);
         end
         if (exp_v) begin
            e = exp_c.pop_front();
            n_assert++;
            if (out_data_c !== e.data) begin
               n_fail++;
               $display("FAIL rst_mid_data cyc=%0d: got %h want %h", cyc, out_data_c, e.data);
            end
         end
         if (i == 2) begin
            n_assert++;
            if (out_data_c !== '0 || ovr_flag_c !== '0 || ovr_count_c !== '0) begin
               n_fail++;
               $display("FAIL rst_mid_values: got data=%h flag=%h count=%h want 0/0/0",
                        out_data_c, ovr_flag_c, ovr_count_c);
            end
         end
      end
      rst_c      = 1'b0;
      in_valid_c = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; mode_a = 2'b00; ovr_clr_a = 1'b0;
      rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; mode_b = 2'b00; ovr_clr_b = 1'b0;
      rst_c = 1'b1; in_valid_c = 1'b0; in_data_c = '0; mode_c = 2'b00; ovr_clr_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      test_exhaustive();
      test_twos();
      test_over_range();
      test_mode_switch();
      test_gapped();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
